flash_sample_reader: RTL and testbench
======================================

FLASH_SAMPLE_READER -- requirements
Module: flash_sample_reader

Interface
REQ-001 Parameter DATA_TIMEOUT, 255, cycles to wait in WAIT_DATA for flash_mem_readdatavalid before declaring an error; legal range 1-255.
REQ-002 clock  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pause  in  1  1 = hold playback; no new fetch started, no sample emitted.
REQ-005 sample_tick  in  1  one-cycle audio-rate strobe requesting the next sample.
REQ-006 fetch_address_enable  out  1  one-cycle request to the upstream address generator for the next address.
REQ-007 address_in  in  24  address from the upstream generator.
REQ-008 address_ready  in  1  upstream pulse: address_in is valid.
REQ-009 flash_mem_read  out  1  Avalon-MM read request.
REQ-010 flash_mem_address  out  23  Avalon-MM word address.
REQ-011 flash_mem_byteenable  out  4  Avalon-MM byte enables.
REQ-012 flash_mem_waitrequest  in  1  Avalon-MM stall.
REQ-013 flash_mem_readdata  in  32  Avalon-MM read data.
REQ-014 flash_mem_readdatavalid  in  1  Avalon-MM read data valid.
REQ-015 sample_out  out  16  current audio sample, held between updates.
REQ-016 sample_valid  out  1  one-cycle pulse when sample_out updates.
REQ-017 read_error  out  1  sticky flag: a flash read timed out.

Function
REQ-018 The FSM SHALL have states IDLE, REQ_ADDR, WAIT_ADDR, FLASH_READ, WAIT_DATA, OUT_LOW, OUT_HIGH.
REQ-019 IDLE SHALL go to REQ_ADDR when pause=0 and stay otherwise.
REQ-020 REQ_ADDR SHALL assert fetch_address_enable for exactly one cycle, then go to WAIT_ADDR.
REQ-021 WAIT_ADDR SHALL detect a rising edge of address_ready (current 1, previous-cycle registered value 0), latch address_in[22:0] into flash_mem_address, and go to FLASH_READ; address_in[23] is ignored.
REQ-022 FLASH_READ SHALL hold flash_mem_read=1 with constant flash_mem_address while flash_mem_waitrequest=1, deassert flash_mem_read in the cycle after waitrequest=0, and go to WAIT_DATA.
REQ-023 flash_mem_byteenable SHALL be constant 4'hF.
REQ-024 WAIT_DATA SHALL capture flash_mem_readdata into a 32-bit word register on the cycle readdatavalid=1 and go to OUT_LOW.
REQ-025 In WAIT_DATA, an 8-bit counter cleared on entry SHALL increment each cycle; when it reaches DATA_TIMEOUT without readdatavalid, the word register SHALL load 32'h0, read_error SHALL set, and the FSM SHALL go to OUT_LOW.
REQ-026 readdatavalid outside WAIT_DATA SHALL be ignored.
REQ-027 OUT_LOW SHALL, on a cycle with sample_tick=1 and pause=0, load sample_out<=word[15:0], pulse sample_valid, and go to OUT_HIGH.
REQ-028 OUT_HIGH SHALL, on a cycle with sample_tick=1 and pause=0, load sample_out<=word[31:16], pulse sample_valid, and go to IDLE.
REQ-029 A sample_tick arriving with pause=1, or in any state other than OUT_LOW/OUT_HIGH, SHALL be dropped (not queued).
REQ-030 pause SHALL NOT abort an in-flight fetch or flash read; the FSM SHALL complete the read and wait in OUT_LOW.
REQ-031 sample_out SHALL hold its last value whenever sample_valid=0.
REQ-032 read_error SHALL remain 1 until reset.

Reset
REQ-033 Reset SHALL, in any state including mid-read, force IDLE, clear the WAIT_DATA counter, word register and address_ready edge register, and drive fetch_address_enable=0, flash_mem_read=0, flash_mem_address=0, sample_out=0, sample_valid=0, read_error=0.
REQ-034 Reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-035 Normal play: pause=0, address_ready pulse with address_in=24'h000010, waitrequest 0, readdata=32'hBEEF1234 after 3 cycles, two ticks -> flash_mem_address=23'h10, sample_out 16'h1234 then 16'hBEEF, two sample_valid pulses, new fetch_address_enable pulse.
REQ-036 Waitrequest stall: waitrequest=1 for 5 cycles -> flash_mem_read held 1 with address stable for 6 cycles, single read issued.
REQ-037 Timeout: DATA_TIMEOUT=4, no readdatavalid -> read_error=1 after 4 WAIT_DATA cycles, next two ticks emit 16'h0000 twice, read_error stays 1.
REQ-038 Pause: pause=1 asserted during FLASH_READ -> read completes, ticks produce no sample_valid; pause=0 -> next tick emits low half.
REQ-039 Reset mid-read: reset in WAIT_DATA with later readdatavalid -> all outputs 0, data ignored, FSM restarts from IDLE.
REQ-040 Upstream wrap: address_in=24'h07FFFF then 24'h000000 -> flash_mem_address 23'h7FFFF then 23'h00000, continuous playback.

Source files
------------

// File: rtl/flash_sample_reader.sv
// Fetches one 32-bit word per address from an Avalon-MM flash port and plays
// it back as two 16-bit audio samples (low half first), one per sample_tick.
// A read that never returns data is replaced by silence and flagged sticky.
module flash_sample_reader #(
  parameter int unsigned DATA_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        pause,
  input  logic        sample_tick,
  output logic        fetch_address_enable,
  input  logic [23:0] address_in,
  input  logic        address_ready,
  output logic        flash_mem_read,
  output logic [22:0] flash_mem_address,
  output logic [3:0]  flash_mem_byteenable,
  input  logic        flash_mem_waitrequest,
  input  logic [31:0] flash_mem_readdata,
  input  logic        flash_mem_readdatavalid,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        read_error
);

  typedef enum logic [2:0] {
    IDLE,
    REQ_ADDR,
    WAIT_ADDR,
    FLASH_READ,
    WAIT_DATA,
    OUT_LOW,
    OUT_HIGH
  } state_t;

  // Counter runs 0..DATA_TIMEOUT-1 across the WAIT_DATA cycles, so the
  // timeout fires on the DATA_TIMEOUT-th cycle spent waiting.
  localparam logic [7:0] LAST_COUNT = 8'(DATA_TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic        ready_q;
  logic [7:0]  wait_count;
  logic [31:0] word;

  logic        addr_rise;
  logic        latch_addr;
  logic        load_word;
  logic        time_out;
  logic        emit_low;
  logic        emit_high;

  // Flash is word-addressed over 23 bits; the top upstream address bit is dropped.
  logic        unused_addr_msb;
  assign unused_addr_msb = address_in[23];

  assign addr_rise            = address_ready & ~ready_q;
  assign flash_mem_byteenable = 4'hF;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and Moore/Mealy strobes for the datapath.
  always_comb begin
    next_state           = state;
    fetch_address_enable = 1'b0;
    flash_mem_read       = 1'b0;
    latch_addr           = 1'b0;
    load_word            = 1'b0;
    time_out             = 1'b0;
    emit_low             = 1'b0;
    emit_high            = 1'b0;
    case (state)
      IDLE: begin
        if (!pause) begin
          next_state = REQ_ADDR;
        end
      end
      REQ_ADDR: begin
        fetch_address_enable = 1'b1;
        next_state           = WAIT_ADDR;
      end
      WAIT_ADDR: begin
        if (addr_rise) begin
          latch_addr = 1'b1;
          next_state = FLASH_READ;
        end
      end
      FLASH_READ: begin
        flash_mem_read = 1'b1;
        if (!flash_mem_waitrequest) begin
          next_state = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          load_word  = 1'b1;
          next_state = OUT_LOW;
        end else if (wait_count == LAST_COUNT) begin
          time_out   = 1'b1;
          next_state = OUT_LOW;
        end
      end
      OUT_LOW: begin
        if (sample_tick && !pause) begin
          emit_low   = 1'b1;
          next_state = OUT_HIGH;
        end
      end
      OUT_HIGH: begin
        if (sample_tick && !pause) begin
          emit_high  = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: address latch, timeout counter, word buffer and sample output.
  always_ff @(posedge clock) begin
    if (reset) begin
      ready_q           <= 1'b0;
      wait_count        <= '0;
      word              <= '0;
      flash_mem_address <= '0;
      sample_out        <= '0;
      sample_valid      <= 1'b0;
      read_error        <= 1'b0;
    end else begin
      ready_q      <= address_ready;
      sample_valid <= emit_low | emit_high;

      if (latch_addr) begin
        flash_mem_address <= address_in[22:0];
      end

      if (state == WAIT_DATA) begin
        wait_count <= wait_count + 8'd1;
      end else begin
        wait_count <= '0;
      end

      if (load_word) begin
        word <= flash_mem_readdata;
      end else if (time_out) begin
        word <= '0;
      end

      if (time_out) begin
        read_error <= 1'b1;
      end

      if (emit_low) begin
        sample_out <= word[15:0];
      end else if (emit_high) begin
        sample_out <= word[31:16];
      end
    end
  end

endmodule

// File: tb/tb_flash_sample_reader.sv
// Directed bench for flash_sample_reader: normal play, waitrequest stall,
// data timeout, pause handling, address wrap and reset during a read.
module tb_flash_sample_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        pause;
  logic        sample_tick;
  logic        fetch_address_enable;
  logic [23:0] address_in;
  logic        address_ready;
  logic        flash_mem_read;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic        flash_mem_waitrequest;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;
  logic [15:0] sample_out;
  logic        sample_valid;
  logic        read_error;

  int errors   = 0;
  int checks   = 0;
  int accepted = 0;

  flash_sample_reader #(.DATA_TIMEOUT(4)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .pause                   (pause),
    .sample_tick             (sample_tick),
    .fetch_address_enable    (fetch_address_enable),
    .address_in              (address_in),
    .address_ready           (address_ready),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .sample_out              (sample_out),
    .sample_valid            (sample_valid),
    .read_error              (read_error)
  );

  always #5 clock = ~clock;

  // Count Avalon read transactions actually accepted by the slave.
  always @(posedge clock) begin
    if (flash_mem_read === 1'b1 && flash_mem_waitrequest === 1'b0) accepted++;
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the address request pulse.
  task automatic wait_fae(input string tag);
    int unsigned n;
    n = 0;
    while (fetch_address_enable !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    check(tag, fetch_address_enable, 1);
  endtask

  // Called in the REQ_ADDR cycle; answers with an address_ready pulse.
  task automatic issue_addr(input logic [23:0] a);
    step();
    check("fae_one_cycle", fetch_address_enable, 0);
    address_in    = a;
    address_ready = 1'b1;
    step();
    address_ready = 1'b0;
  endtask

  // Called in the first FLASH_READ cycle; stalls for 'stall' cycles.
  task automatic run_read(input int unsigned stall, input logic [22:0] exp_addr);
    int unsigned high;
    bit          moved;
    int          start;
    high  = 0;
    moved = 0;
    start = accepted;
    for (int unsigned i = 0; i <= stall; i++) begin
      flash_mem_waitrequest = (i < stall);
      if (flash_mem_read === 1'b1) high++;
      if (flash_mem_address !== exp_addr) moved = 1;
      step();
    end
    flash_mem_waitrequest = 1'b0;
    check("addr", flash_mem_address, exp_addr);
    check("read_cycles", high, stall + 1);
    check("addr_stable", moved, 0);
    check("read_dropped", flash_mem_read, 0);
    check("single_read", accepted - start, 1);
  endtask

  // Called in WAIT_DATA cycle 1; data valid on WAIT_DATA cycle 'dly'.
  task automatic give_data(input int unsigned dly, input logic [31:0] d);
    repeat (dly - 1) step();
    flash_mem_readdata      = d;
    flash_mem_readdatavalid = 1'b1;
    step();
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = '0;
  endtask

  task automatic emit(input logic [15:0] exp);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("emit_valid", sample_valid, 1);
    check("emit_value", sample_out, exp);
    step();
    check("valid_pulse_end", sample_valid, 0);
    check("sample_hold", sample_out, exp);
  endtask

  task automatic drop_tick(input logic [15:0] held);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("dropped_tick_valid", sample_valid, 0);
    check("dropped_tick_hold", sample_out, held);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                   = 1'b1;
    pause                   = 1'b1;
    sample_tick             = 1'b0;
    address_in              = '0;
    address_ready           = 1'b0;
    flash_mem_waitrequest   = 1'b0;
    flash_mem_readdata      = '0;
    flash_mem_readdatavalid = 1'b0;
    step();
    step();
    check("rst_fae", fetch_address_enable, 0);
    check("rst_read", flash_mem_read, 0);
    check("rst_addr", flash_mem_address, 0);
    check("rst_sample", sample_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_error", read_error, 0);
    check("byteenable", flash_mem_byteenable, 4'hF);
    reset = 1'b0;

    // Paused in IDLE: no fetch, ticks dropped.
    step();
    step();
    check("paused_idle_fae", fetch_address_enable, 0);
    drop_tick(16'h0000);

    // Normal play.
    pause = 1'b0;
    wait_fae("fae_first");
    issue_addr(24'h000010);
    run_read(0, 23'h000010);
    give_data(3, 32'hBEEF1234);
    check("pre_tick_valid", sample_valid, 0);
    check("pre_tick_hold", sample_out, 16'h0000);
    emit(16'h1234);
    emit(16'hBEEF);
    wait_fae("fae_refetch");

    // Waitrequest stall; a tick while waiting for data is dropped.
    issue_addr(24'h000020);
    run_read(5, 23'h000020);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    give_data(1, 32'hCAFE5678);
    check("wait_tick_dropped", sample_valid, 0);
    emit(16'h5678);
    emit(16'hCAFE);
    wait_fae("fae_after_stall");

    // Timeout after four WAIT_DATA cycles; late data ignored.
    issue_addr(24'h000030);
    run_read(0, 23'h000030);
    check("err_cycle1", read_error, 0);
    repeat (3) step();
    check("err_not_early", read_error, 0);
    step();
    check("err_set", read_error, 1);
    flash_mem_readdata      = 32'hFFFFFFFF;
    flash_mem_readdatavalid = 1'b1;
    step();
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = '0;
    check("late_data_valid", sample_valid, 0);
    check("late_data_hold", sample_out, 16'hCAFE);
    emit(16'h0000);
    check("err_sticky1", read_error, 1);
    emit(16'h0000);
    check("err_sticky2", read_error, 1);
    wait_fae("fae_after_timeout");

    // Pause raised during the flash read: read completes, ticks held off.
    issue_addr(24'h000040);
    pause = 1'b1;
    run_read(2, 23'h000040);
    give_data(2, 32'h11112222);
    drop_tick(16'h0000);
    drop_tick(16'h0000);
    pause = 1'b0;
    emit(16'h2222);
    emit(16'h1111);
    wait_fae("fae_after_pause");

    // Address wrap and ignored MSB, continuous playback.
    issue_addr(24'h07FFFF);
    run_read(0, 23'h07FFFF);
    give_data(1, 32'h00020001);
    emit(16'h0001);
    emit(16'h0002);
    wait_fae("fae_wrap1");
    issue_addr(24'h000000);
    run_read(0, 23'h000000);
    give_data(2, 32'h00040003);
    emit(16'h0003);
    emit(16'h0004);
    wait_fae("fae_wrap2");
    issue_addr(24'h800005);
    run_read(0, 23'h000005);
    give_data(1, 32'h00060005);
    emit(16'h0005);
    emit(16'h0006);
    check("err_still_set", read_error, 1);
    wait_fae("fae_wrap3");

    // Reset in WAIT_DATA; data arriving afterwards is ignored.
    issue_addr(24'h000055);
    run_read(0, 23'h000055);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_fae", fetch_address_enable, 0);
    check("mid_rst_read", flash_mem_read, 0);
    check("mid_rst_addr", flash_mem_address, 0);
    check("mid_rst_sample", sample_out, 0);
    check("mid_rst_valid", sample_valid, 0);
    check("mid_rst_error", read_error, 0);
    flash_mem_readdata      = 32'hDEADBEEF;
    flash_mem_readdatavalid = 1'b1;
    step();
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = '0;
    wait_fae("fae_after_reset");
    issue_addr(24'h000066);
    run_read(0, 23'h000066);
    give_data(1, 32'h0A0B0C0D);
    emit(16'h0C0D);
    emit(16'h0A0B);
    check("err_clear_after_reset", read_error, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
